// File: rtl/packet_deserializer.sv
// packet_deserializer
// Collects DATA_WIDTH-bit lane words into one DATA_DEPTH-row frame. A frame is
// DATA_DEPTH words in the 64-bit format or DATA_DEPTH/2 words in the 16-bit
// format. The frame is held until the downstream stage accepts it with a
// valid/ready handshake. Alignment, mid-frame SOF and overflow conditions are
// reported as single-cycle error pulses.
//
// state   | meaning
// IDLE    | waiting for a start-of-frame word
// COLLECT | filling rows 1..len-1 of the current frame
// HOLD    | complete frame presented, waiting for frame_ready
module packet_deserializer #(
  parameter int DATA_WIDTH = 10,
  parameter int DATA_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enc_used,
  input  logic [DATA_WIDTH-1:0]                  word_in,
  input  logic                                   word_valid,
  input  logic                                   word_sof,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  par_out,
  output logic                                   frame_enc_used,
  output logic                                   frame_valid,
  input  logic                                   frame_ready,
  output logic                                   err_align,
  output logic                                   err_sof,
  output logic                                   err_ovf
);

  localparam int CW = $clog2(DATA_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                                 state_q;
  logic [CW-1:0]                          cnt_q;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  par_q;
  logic                                   enc_q;
  logic                                   valid_q;
  logic                                   err_align_q;
  logic                                   err_sof_q;
  logic                                   err_ovf_q;

  logic [CW-1:0]                          last_idx;
  logic                                   start_frame;

  // Index of the final row for the format latched at SOF.
  assign last_idx = enc_q ? CW'(DATA_DEPTH / 2 - 1) : CW'(DATA_DEPTH - 1);

  // An SOF starts a new frame from IDLE, mid-frame, or in the cycle a held frame is accepted.
  assign start_frame = word_valid & word_sof &
                       ((state_q == IDLE) | (state_q == COLLECT) |
                        ((state_q == HOLD) & frame_ready));

  // Frame assembly FSM; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      par_q       <= '0;
      enc_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_align_q <= 1'b0;
      err_sof_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_align_q <= 1'b0;
      err_sof_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      if (start_frame) begin
        // Clearing every row keeps the unused upper half zero in the 16-bit format.
        par_q    <= '0;
        par_q[0] <= word_in;
        enc_q    <= enc_used;
        cnt_q    <= CW'(1);
        valid_q  <= 1'b0;
        state_q  <= COLLECT;
        if (state_q == COLLECT) begin
          err_sof_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (word_valid) begin
              err_align_q <= 1'b1;
            end
          end
          COLLECT: begin
            if (word_valid) begin
              par_q[cnt_q] <= word_in;
              cnt_q        <= cnt_q + 1'b1;
              if (cnt_q == last_idx) begin
                valid_q <= 1'b1;
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (word_valid) begin
              err_ovf_q <= 1'b1;
            end
            if (frame_ready) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign par_out        = par_q;
  assign frame_enc_used = enc_q;
  assign frame_valid    = valid_q;
  assign err_align      = err_align_q;
  assign err_sof        = err_sof_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: doc/packet_deserializer.md
# packet_deserializer

Receive-side frame assembler between the lane word receiver and `packet_unscramble`. It collects a stream of `DATA_WIDTH`-bit lane words into one `DATA_DEPTH`-word parallel frame and presents that frame with a valid/ready handshake. Frame length depends on the encoding cluster in use: 8 words for the 64-bit format, 4 words for the 16-bit format. It also reports alignment and overflow errors to the UL FEC status logic.

## Interface
Parameters:
- `DATA_WIDTH`, 10, bits per lane word; matches the frame row width.
- `DATA_DEPTH`, 8, words per 64-bit frame; the 16-bit frame uses `DATA_DEPTH/2`.

Ports:
- `clk`  in  1  block clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enc_used`  in  1  frame format: 0 = 64-bit cluster (`DATA_DEPTH` words), 1 = 16-bit cluster (`DATA_DEPTH/2` words). Sampled only on the start-of-frame word.
- `word_in`  in  `DATA_WIDTH`  lane word.
- `word_valid`  in  1  `word_in` is valid this cycle.
- `word_sof`  in  1  qualifies `word_in` as word 0 of a frame. Ignored unless `word_valid` is high.
- `par_out`  out  `DATA_DEPTH` x `DATA_WIDTH` (packed `[DATA_DEPTH-1:0][DATA_WIDTH-1:0]`)  assembled frame; row i holds the i-th received word.
- `frame_enc_used`  out  1  `enc_used` latched at start of frame.
- `frame_valid`  out  1  `par_out` and `frame_enc_used` hold a complete frame.
- `frame_ready`  in  1  downstream accepts the frame.
- `err_align`  out  1  one-cycle pulse: a non-SOF word arrived while IDLE and was discarded.
- `err_sof`  out  1  one-cycle pulse: an SOF arrived mid-frame and the partial frame was discarded.
- `err_ovf`  out  1  one-cycle pulse: a word arrived while a frame was held and was dropped.

## Operation
- Frame length: `len = enc_used_latched ? DATA_DEPTH/2 : DATA_DEPTH`.
- Word index counter `cnt` is `$clog2(DATA_DEPTH)` bits wide.
- FSM states:
  - **IDLE**
    - `word_valid & word_sof`: clear all of `par_out`, write `word_in` to row 0, latch `enc_used` into `frame_enc_used`, set `cnt = 1`, go to COLLECT.
    - `word_valid & !word_sof`: discard the word, pulse `err_align`.
  - **COLLECT**
    - `word_valid & !word_sof`: write row `cnt`, then `cnt++`. If `cnt == len-1` before the increment, go to HOLD and set `frame_valid`.
    - `word_valid & word_sof`: pulse `err_sof` and restart exactly as the IDLE SOF case (clear rows, row 0 = word, relatch format, `cnt = 1`).
    - No `word_valid`: hold state; gaps between words are unlimited.
  - **HOLD**
    - `frame_valid = 1`; `par_out` and `frame_enc_used` are stable.
    - `frame_ready` high: frame is consumed and `frame_valid` clears. If the same cycle has `word_valid & word_sof`, start a new frame (IDLE SOF action) and go to COLLECT; otherwise go to IDLE.
    - `frame_ready` high with `word_valid & !word_sof`: the word is dropped and `err_ovf` pulses; go to IDLE.
    - `frame_ready` low with `word_valid`: the word is dropped (SOF or not), `err_ovf` pulses, stay in HOLD.
- 16-bit format: rows `DATA_DEPTH/2 .. DATA_DEPTH-1` stay zero, because they are cleared at SOF.
- Only one error pulse can occur per cycle; the conditions are mutually exclusive by state.

## Timing
- Reset values: state IDLE, `cnt = 0`, `par_out = 0`, `frame_enc_used = 0`, `frame_valid = 0`, `err_align = err_sof = err_ovf = 0`.
- Reset asserted mid-frame or in HOLD discards all content on that edge.
- Every output is registered; there is no combinational path from input to output.
- Latency: the last word is sampled at edge N, and `frame_valid` is high from edge N through the accepting edge.
- Handshake: the transfer occurs on an edge where `frame_valid & frame_ready` are both high. `frame_valid` is low the following cycle unless `DATA_DEPTH/2 == 1`, which is not supported; minimum `DATA_DEPTH` is 4.
- `frame_ready` is ignored outside HOLD.
- Error pulses are high for exactly the one cycle after the offending edge.
- Throughput: back-to-back frames with no idle cycles are lossless only if `frame_ready` is high in the HOLD cycle that coincides with the next SOF.

## Test plan
- **64-bit frame:** reset, `enc_used = 0`, SOF plus 8 consecutive words `10'h001..10'h008`. Required: `frame_valid` rises after the 8th edge, `par_out[0] = 10'h001`, `par_out[7] = 10'h008`, `frame_enc_used = 0`. Assert `frame_ready` for one cycle; `frame_valid` then returns to 0.
- **16-bit frame:** `enc_used = 1`, SOF plus 4 words `10'h3FF, 10'h155, 10'h2AA, 10'h001`, with `enc_used` toggled to 0 mid-frame. Required: `frame_valid` after word 4, rows 4..7 = 0, `frame_enc_used = 1`.
- **SOF mid-frame:** SOF, 3 words, then a new SOF plus 8 words (`enc_used = 0`). Required: `err_sof` pulses once, and the output frame contains only the second frame's 8 words.
- **Alignment:** 2 non-SOF words in IDLE. Required: `err_align` pulses twice and `frame_valid` stays 0. A subsequent SOF frame is assembled correctly.
- **Backpressure:** complete a frame, hold `frame_ready = 0`, send 2 words. Required: `err_ovf` pulses twice and `par_out` is unchanged. Then `frame_ready = 1` in the same cycle as a new SOF: the frame is accepted and the next frame starts with row 0 = SOF word.
- **Reset mid-frame:** SOF plus 5 words, then `rst` for 1 cycle. Required: all outputs return to 0, and a following full frame is assembled without error pulses.
